// File: rtl/bubble_ctrl_pkg.sv
// Shared encodings for the BUBBLE sequencer: opcodes, functs, ALU select codes, FSM states
// and instruction classes, plus the branch-target helper.
package bubble_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SUBI  = 6'b011010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALU_SEL_IDLE = 2'b00;
  localparam logic [1:0] ALU_SEL_R    = 2'b01;
  localparam logic [1:0] ALU_SEL_I    = 2'b10;
  localparam logic [1:0] ALU_SEL_J    = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT, ST_ERR
  } state_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_BEQ, CLS_J, CLS_HALT, CLS_ILL
  } cls_t;

  // Taken-branch target: pc + 4 + (sign-extended word offset << 2), mod 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [15:0] imm);
    return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/bubble_decode.sv
// Combinational instruction classifier: class, legality, ALU select/op/funct and
// writeback register for the latched IR. Zero latency, no flow control.
module bubble_decode
  import bubble_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output cls_t        cls,
  output logic        legal,
  output logic [1:0]  alu_sel,
  output logic [5:0]  alu_op,
  output logic [5:0]  alu_funct,
  output logic [4:0]  rf_waddr
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_ir;

  assign opcode    = ir[31:26];
  assign funct     = ir[5:0];
  assign unused_ir = ^{ir[25:21], ir[10:6]};

  always_comb begin
    cls       = CLS_ILL;
    alu_sel   = ALU_SEL_IDLE;
    alu_op    = 6'b0;
    alu_funct = 6'b0;
    case (opcode)
      OP_RTYPE: begin
        if (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}) begin
          cls       = CLS_R;
          alu_sel   = ALU_SEL_R;
          alu_funct = funct;
        end
      end
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: begin
        cls     = CLS_I;
        alu_sel = ALU_SEL_I;
        alu_op  = opcode;
      end
      // Address generation for loads and stores reuses the immediate adder.
      OP_LW, OP_SW: begin
        cls     = (opcode == OP_LW) ? CLS_LW : CLS_SW;
        alu_sel = ALU_SEL_I;
        alu_op  = OP_ADDI;
      end
      OP_BEQ: begin
        cls       = CLS_BEQ;
        alu_sel   = ALU_SEL_R;
        alu_funct = FN_SUB;
      end
      OP_J: begin
        cls     = CLS_J;
        alu_sel = ALU_SEL_J;
      end
      OP_HALT: cls = CLS_HALT;
      default: cls = CLS_ILL;
    endcase
  end

  assign legal    = (cls != CLS_ILL);
  assign rf_waddr = (cls == CLS_R) ? ir[15:11] : ir[20:16];

endmodule

// File: rtl/bubble_exec_ctrl.sv
// Multi-cycle BUBBLE sequencer: fetch, decode, exec, mem, writeback; all outputs registered
// from next state. R-type 4 cycles, lw 5 + ack wait, sw 4 + ack wait; stalls on imem_valid/dmem_ack.
module bubble_exec_ctrl
  import bubble_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned DMEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [1:0]  alu_sel,
  output logic [5:0]  alu_funct,
  output logic [5:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic [31:0] alu_new_pc,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic        rf_wsel,
  output logic [31:0] instret,
  output logic        halted,
  output logic        err
);

  localparam logic [15:0] TMO_LIM = 16'(DMEM_TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instret_q, instret_d;
  logic [15:0] tmo_q, tmo_d;

  logic        imem_req_q, imem_req_d;
  logic [1:0]  alu_sel_q, alu_sel_d;
  logic [5:0]  alu_funct_q, alu_funct_d;
  logic [5:0]  alu_op_q, alu_op_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic        rf_wsel_q, rf_wsel_d;
  logic        halted_q, halted_d;
  logic        err_q, err_d;

  cls_t        dec_cls;
  logic        dec_legal;
  logic [1:0]  dec_alu_sel;
  logic [5:0]  dec_alu_op;
  logic [5:0]  dec_alu_funct;
  logic [4:0]  dec_rf_waddr;
  logic [31:0] pc_plus4;
  logic        unused_alu_result;

  // The result word is steered to the register file by rf_wsel, not through this block.
  assign unused_alu_result = ^alu_result;
  assign pc_plus4          = pc_q + 32'd4;

  bubble_decode u_decode (
    .ir        (ir_q),
    .cls       (dec_cls),
    .legal     (dec_legal),
    .alu_sel   (dec_alu_sel),
    .alu_op    (dec_alu_op),
    .alu_funct (dec_alu_funct),
    .rf_waddr  (dec_rf_waddr)
  );

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    pc_d      = pc_q;
    instret_d = instret_q;
    tmo_d     = tmo_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_req_q && imem_valid) begin
          ir_d    = imem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!dec_legal)                state_d = ST_ERR;
        else if (dec_cls == CLS_HALT)  state_d = ST_HALT;
        else                           state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (dec_cls)
          CLS_LW, CLS_SW: begin
            tmo_d   = 16'd0;
            state_d = ST_MEM;
          end
          CLS_BEQ: begin
            pc_d      = alu_zero ? branch_target(pc_q, ir_q[15:0]) : pc_plus4;
            instret_d = instret_q + 32'd1;
            state_d   = ST_FETCH;
          end
          CLS_J: begin
            pc_d      = alu_new_pc;
            instret_d = instret_q + 32'd1;
            state_d   = ST_FETCH;
          end
          default: state_d = ST_WB;
        endcase
      end
      // An ack in the same cycle the wait budget runs out still completes the access.
      ST_MEM: begin
        if (dmem_ack) begin
          tmo_d = 16'd0;
          if (dec_cls == CLS_SW) begin
            pc_d      = pc_plus4;
            instret_d = instret_q + 32'd1;
            state_d   = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else begin
          tmo_d = tmo_q + 16'd1;
          if (tmo_d == TMO_LIM) state_d = ST_ERR;
        end
      end
      ST_WB: begin
        pc_d      = pc_plus4;
        instret_d = instret_q + 32'd1;
        state_d   = ST_FETCH;
      end
      default: state_d = state_q;
    endcase

    imem_req_d  = (state_d == ST_FETCH);
    alu_sel_d   = (state_d == ST_EXEC) ? dec_alu_sel   : ALU_SEL_IDLE;
    alu_op_d    = (state_d == ST_EXEC) ? dec_alu_op    : 6'b0;
    alu_funct_d = (state_d == ST_EXEC) ? dec_alu_funct : 6'b0;
    dmem_req_d  = (state_d == ST_MEM);
    dmem_we_d   = (state_d == ST_MEM) && (dec_cls == CLS_SW);
    rf_waddr_d  = (state_d == ST_WB) ? dec_rf_waddr : 5'd0;
    rf_we_d     = (state_d == ST_WB) && (dec_rf_waddr != 5'd0);
    rf_wsel_d   = (state_d == ST_WB) && (dec_cls == CLS_LW);
    halted_d    = (state_d == ST_HALT);
    err_d       = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      ir_q        <= 32'd0;
      pc_q        <= RESET_PC;
      instret_q   <= 32'd0;
      tmo_q       <= 16'd0;
      imem_req_q  <= 1'b0;
      alu_sel_q   <= ALU_SEL_IDLE;
      alu_funct_q <= 6'b0;
      alu_op_q    <= 6'b0;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= 5'd0;
      rf_wsel_q   <= 1'b0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      pc_q        <= pc_d;
      instret_q   <= instret_d;
      tmo_q       <= tmo_d;
      imem_req_q  <= imem_req_d;
      alu_sel_q   <= alu_sel_d;
      alu_funct_q <= alu_funct_d;
      alu_op_q    <= alu_op_d;
      dmem_req_q  <= dmem_req_d;
      dmem_we_q   <= dmem_we_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wsel_q   <= rf_wsel_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign pc        = pc_q;
  assign alu_sel   = alu_sel_q;
  assign alu_funct = alu_funct_q;
  assign alu_op    = alu_op_q;
  assign dmem_req  = dmem_req_q;
  assign dmem_we   = dmem_we_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wsel   = rf_wsel_q;
  assign instret   = instret_q;
  assign halted    = halted_q;
  assign err       = err_q;

endmodule
